// File: rtl/seg_disp_sched.sv
// ============================================================================
//  Module   : seg_disp_sched
//  Purpose  : Scan scheduler and page arbiter for the 4-digit elevator
//             7-segment display. Scans digits with anti-ghost blanking,
//             applies per-digit blink and switches between normal, alarm
//             and one-shot message pages on frame boundaries only.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_disp_sched #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 2,
    parameter int BLINK_SLOTS = 256,
    parameter int HOLD_FRAMES = 200
) (
    input  logic        clk,
    input  logic        sysclr_n,
    input  logic [27:0] norm_pat,
    input  logic [3:0]  norm_blink,
    input  logic        alarm_req,
    input  logic [27:0] alarm_pat,
    input  logic        msg_req,
    input  logic [27:0] msg_pat,
    output logic        msg_ack,
    output logic [1:0]  page,
    output logic        frame_done,
    output logic [5:0]  SEG_SEL_n,
    output logic [7:0]  SEG_DATA
);

    localparam logic [0:0]  c_ST_BLANK    = 1'b0;
    localparam logic [0:0]  c_ST_DRIVE    = 1'b1;
    localparam logic [1:0]  c_PAGE_NORM   = 2'd0;
    localparam logic [1:0]  c_PAGE_ALARM  = 2'd1;
    localparam logic [1:0]  c_PAGE_MSG    = 2'd2;
    localparam logic [19:0] c_SCAN_LAST   = 20'(SCAN_DIV - 1);
    localparam logic [19:0] c_BLANK_LAST  = 20'(BLANK_CYC - 1);
    localparam logic [15:0] c_BLINK_LAST  = 16'(BLINK_SLOTS - 1);
    localparam logic [15:0] c_HOLD_INIT   = 16'(HOLD_FRAMES);

    logic [0:0]  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blink_off_q, blink_off_d;
    logic [1:0]  page_q, page_d;
    logic        pend_q, pend_d;
    logic [15:0] hold_q, hold_d;
    logic [27:0] snap_q, snap_d;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  data_q, data_d;
    logic        ack_q, ack_d;
    logic        fd_q, fd_d;

    logic        w_slot_end;
    logic        w_blank_end;
    logic        w_frame_end;
    logic [15:0] w_hold_dec;
    logic        w_hold_active;
    logic        w_accept;
    logic [27:0] w_pat;
    logic [3:0]  w_mask;
    logic [6:0]  w_digit_pat;

    // Scan sequencing: BLANK/DRIVE timing, digit advance and blink phase.
    always_comb begin
        w_slot_end  = (state_q == c_ST_DRIVE) && (cnt_q == c_SCAN_LAST);
        w_blank_end = (state_q == c_ST_BLANK) && (cnt_q == c_BLANK_LAST);
        w_frame_end = w_slot_end && (digit_q == 2'd3);
        state_d     = state_q;
        cnt_d       = cnt_q + 20'd1;
        digit_d     = digit_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (w_blank_end) begin
            state_d = c_ST_DRIVE;
            cnt_d   = 20'd0;
        end else if (w_slot_end) begin
            state_d = c_ST_BLANK;
            cnt_d   = 20'd0;
            digit_d = digit_q + 2'd1;
            if (blink_cnt_q == c_BLINK_LAST) begin
                blink_cnt_d = 16'd0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    // Page arbitration at frame boundaries: alarm > message > normal.
    always_comb begin
        w_hold_dec    = (w_frame_end && (page_q == c_PAGE_MSG) && (hold_q != 16'd0))
                        ? hold_q - 16'd1 : hold_q;
        w_hold_active = (page_q == c_PAGE_MSG) && (w_hold_dec != 16'd0);
        w_accept      = w_frame_end && !alarm_req && !w_hold_active && (pend_q || msg_req);
        page_d        = page_q;
        hold_d        = w_hold_dec;
        snap_d        = snap_q;
        pend_d        = w_accept ? 1'b0 : (pend_q | msg_req);
        if (w_frame_end) begin
            if (alarm_req) begin
                page_d = c_PAGE_ALARM;
                hold_d = 16'd0;
            end else if (w_hold_active) begin
                page_d = c_PAGE_MSG;
            end else if (w_accept) begin
                page_d = c_PAGE_MSG;
                hold_d = c_HOLD_INIT;
                snap_d = msg_pat;
            end else begin
                page_d = c_PAGE_NORM;
            end
        end
        ack_d = w_accept;
        fd_d  = w_frame_end;
    end

    // Pin values for the upcoming cycle, from the next scan state and page.
    always_comb begin
        w_pat  = norm_pat;
        w_mask = norm_blink;
        case (page_d)
            c_PAGE_ALARM: begin
                w_pat  = alarm_pat;
                w_mask = 4'hF;
            end
            c_PAGE_MSG: begin
                w_pat  = snap_d;
                w_mask = 4'h0;
            end
            default: ;
        endcase
        case (digit_d)
            2'd0:    w_digit_pat = w_pat[6:0];
            2'd1:    w_digit_pat = w_pat[13:7];
            2'd2:    w_digit_pat = w_pat[20:14];
            default: w_digit_pat = w_pat[27:21];
        endcase
        sel_d  = 6'h3F;
        data_d = 8'hFF;
        if (state_d == c_ST_DRIVE) begin
            sel_d = {2'b11, ~(4'b0001 << digit_d)};
            if (!(blink_off_d && w_mask[digit_d])) begin
                data_d = {1'b1, w_digit_pat};
            end
        end
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!sysclr_n) begin
            state_q     <= c_ST_BLANK;
            cnt_q       <= 20'd0;
            digit_q     <= 2'd0;
            blink_cnt_q <= 16'd0;
            blink_off_q <= 1'b0;
            page_q      <= c_PAGE_NORM;
            pend_q      <= 1'b0;
            hold_q      <= 16'd0;
            snap_q      <= 28'd0;
            sel_q       <= 6'h3F;
            data_q      <= 8'hFF;
            ack_q       <= 1'b0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            page_q      <= page_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            snap_q      <= snap_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            fd_q        <= fd_d;
        end
    end

    assign SEG_SEL_n  = sel_q;
    assign SEG_DATA   = data_q;
    assign page       = page_q;
    assign msg_ack    = ack_q;
    assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_disp_sched.sv
// ============================================================================
//  Module   : tb_seg_disp_sched
//  Purpose  : Scoreboard bench for seg_disp_sched. A frame/slot-level
//             reference model predicts every cycle's pin values; a monitor
//             pops and compares them against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_disp_sched;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BS = 2;
    localparam int HF = 2;
    localparam int SL = SD + BC;
    localparam int FR = 4 * SL;

    typedef struct {
        int         tag;
        logic [5:0] sel;
        logic [7:0] data;
        logic [1:0] page;
        logic       ack;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        sysclr_n;
    logic [27:0] norm_pat;
    logic [3:0]  norm_blink;
    logic        alarm_req;
    logic [27:0] alarm_pat;
    logic        msg_req;
    logic [27:0] msg_pat;
    logic        msg_ack;
    logic [1:0]  page;
    logic        frame_done;
    logic [5:0]  SEG_SEL_n;
    logic [7:0]  SEG_DATA;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    exp_t q[$];

    // reference model state
    int          m_t;
    logic [1:0]  m_page;
    bit          m_pend;
    int          m_hold;
    logic [27:0] m_snap;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    seg_disp_sched #(
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC),
        .BLINK_SLOTS(BS),
        .HOLD_FRAMES(HF)
    ) dut (
        .clk       (clk),
        .sysclr_n  (sysclr_n),
        .norm_pat  (norm_pat),
        .norm_blink(norm_blink),
        .alarm_req (alarm_req),
        .alarm_pat (alarm_pat),
        .msg_req   (msg_req),
        .msg_pat   (msg_pat),
        .msg_ack   (msg_ack),
        .page      (page),
        .frame_done(frame_done),
        .SEG_SEL_n (SEG_SEL_n),
        .SEG_DATA  (SEG_DATA)
    );

    // Predict the pins after the coming edge from current inputs, then clock.
    task automatic tick();
        exp_t        e;
        int          slot;
        int          r;
        int          d;
        bit          off;
        logic [27:0] pat;
        logic [3:0]  mask;
        logic [6:0]  seven;
        e.sel  = 6'h3F;
        e.data = 8'hFF;
        e.ack  = 1'b0;
        e.fd   = 1'b0;
        if (!sysclr_n) begin
            m_t    = 0;
            m_page = 2'd0;
            m_pend = 1'b0;
            m_hold = 0;
            m_snap = '0;
        end else begin
            m_t  = m_t + 1;
            e.fd = ((m_t % FR) == 0);
            if (e.fd) begin
                if (m_page == 2'd2 && m_hold > 0) m_hold = m_hold - 1;
                if (alarm_req) begin
                    m_page = 2'd1;
                    m_hold = 0;
                    if (msg_req) m_pend = 1'b1;
                end else if (m_page == 2'd2 && m_hold > 0) begin
                    if (msg_req) m_pend = 1'b1;
                end else if (m_pend || msg_req) begin
                    m_page = 2'd2;
                    m_snap = msg_pat;
                    m_hold = HF;
                    e.ack  = 1'b1;
                    m_pend = 1'b0;
                end else begin
                    m_page = 2'd0;
                end
            end else if (msg_req) begin
                m_pend = 1'b1;
            end
            slot = m_t / SL;
            r    = m_t % SL;
            if (r >= BC) begin
                d   = slot % 4;
                off = ((slot / BS) % 2) == 1;
                case (m_page)
                    2'd0:    begin pat = norm_pat;  mask = norm_blink; end
                    2'd1:    begin pat = alarm_pat; mask = 4'hF;       end
                    default: begin pat = m_snap;    mask = 4'h0;       end
                endcase
                seven  = pat[d*7 +: 7];
                e.sel  = 6'h3F & ~(6'd1 << d);
                e.data = (off && mask[d]) ? 8'hFF : {1'b1, seven};
            end
        end
        e.page = m_page;
        e.tag  = edge_cnt + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_msg();
        msg_req = 1'b1;
        tick();
        msg_req = 1'b0;
    endtask

    // Advance until the next edge is a frame boundary.
    task automatic to_boundary();
        for (int i = 0; i < FR && ((m_t + 1) % FR) != 0; i++) tick();
    endtask

    // Monitor: compare each edge's expectation away from the active edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tag < edge_cnt) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL stale_expect tag=%0d now=%0d", e.tag, edge_cnt);
            end
            if (q.size() > 0 && q[0].tag == edge_cnt) begin
                e = q.pop_front();
                checks++;
                if (SEG_SEL_n !== e.sel || SEG_DATA !== e.data || page !== e.page ||
                    msg_ack !== e.ack || frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL pins edge=%0d got sel=%h data=%h page=%0d ack=%b fd=%b exp sel=%h data=%h page=%0d ack=%b fd=%b",
                             edge_cnt, SEG_SEL_n, SEG_DATA, page, msg_ack, frame_done,
                             e.sel, e.data, e.page, e.ack, e.fd);
                end
            end
        end
    end

    initial begin : stimulus
        sysclr_n   = 1'b0;
        norm_pat   = {7'h13, 7'h12, 7'h11, 7'h10};
        msg_pat    = {7'h23, 7'h22, 7'h21, 7'h20};
        alarm_pat  = {4{7'h40}};
        norm_blink = 4'h0;
        alarm_req  = 1'b0;
        msg_req    = 1'b0;
        run(2);
        sysclr_n = 1'b1;

        // reset release, message request and snapshot isolation
        run(5);
        pulse_msg();
        run(25);
        msg_pat = 28'h5A5A5A5;
        run(45);
        msg_pat = {7'h23, 7'h22, 7'h21, 7'h20};

        // alarm during a message cancels it
        pulse_msg();
        to_boundary();
        run(5);
        alarm_req = 1'b1;
        run(20);
        alarm_req = 1'b0;
        run(45);

        // normal page blink
        norm_blink = 4'b0001;
        run(80);
        norm_blink = 4'b1100;
        run(80);
        norm_blink = 4'h0;

        // alarm and message at the same boundary
        to_boundary();
        alarm_req = 1'b1;
        pulse_msg();
        run(30);
        alarm_req = 1'b0;
        run(30);

        // message queued behind a displayed message
        pulse_msg();
        to_boundary();
        run(3);
        pulse_msg();
        run(100);

        // reset mid-DRIVE on the message page
        to_boundary();
        pulse_msg();
        for (int i = 0; i < 200 && !(m_page == 2'd2 && ((m_t + 1) % SL) >= BC); i++) tick();
        sysclr_n = 1'b0;
        tick();
        sysclr_n = 1'b1;
        run(60);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39, 0) == 0) msg_req = 1'b1;
            if ($urandom_range(59, 0) == 0) alarm_req = ~alarm_req;
            if ($urandom_range(99, 0) == 0) begin
                norm_pat   = 28'($urandom);
                alarm_pat  = 28'($urandom);
                msg_pat    = 28'($urandom);
                norm_blink = 4'($urandom);
            end
            if ($urandom_range(399, 0) == 0) sysclr_n = 1'b0;
            tick();
            msg_req  = 1'b0;
            sysclr_n = 1'b1;
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expectations exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
